// File: rtl/output_volume_ramp_pkg.sv
// Shared constants, ramp state encoding and peak-magnitude helper for the
// output volume / soft-mute stage.
package output_volume_ramp_pkg;

  localparam int DATA_W = 24;
  localparam int GAIN_W = 16;
  localparam int PROD_W = DATA_W + GAIN_W + 1;
  localparam int PEAK_W = DATA_W - 1;
  localparam logic [GAIN_W-1:0] UNITY = 16'h8000;

  typedef enum logic [1:0] {
    MUTED  = 2'd0,
    RAMP   = 2'd1,
    STEADY = 2'd2
  } ramp_state_t;

  // |x| in PEAK_W bits; the most negative sample saturates to all ones.
  function automatic logic [PEAK_W-1:0] abs_sat(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = ~x + 1'b1;
    if (!x[DATA_W-1]) begin
      return x[PEAK_W-1:0];
    end
    if (x[PEAK_W-1:0] == '0) begin
      return '1;
    end
    return neg[PEAK_W-1:0];
  endfunction

endpackage

// File: rtl/output_volume_ramp_if.sv
// Stereo PCM stream bundle: input strobes/samples and scaled output
// strobes/samples of the volume stage.
interface output_volume_ramp_if;
  import output_volume_ramp_pkg::*;

  logic              l_data_en;
  logic              r_data_en;
  logic [DATA_W-1:0] l_data_in;
  logic [DATA_W-1:0] r_data_in;
  logic              l_data_valid;
  logic              r_data_valid;
  logic [DATA_W-1:0] l_data_out;
  logic [DATA_W-1:0] r_data_out;

  modport master (
    output l_data_en, r_data_en, l_data_in, r_data_in,
    input  l_data_valid, r_data_valid, l_data_out, r_data_out
  );

  modport slave (
    input  l_data_en, r_data_en, l_data_in, r_data_in,
    output l_data_valid, r_data_valid, l_data_out, r_data_out
  );
endinterface

// File: rtl/output_volume_ramp_mult_pipe.sv
// One audio channel: stage 1 captures sample and gain, stage 2 multiplies
// by the Q1.15 gain and truncates back to the sample width.
module volume_mult_pipe
  import output_volume_ramp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic [DATA_W-1:0] data_in,
  input  logic [GAIN_W-1:0] gain,
  output logic              data_valid,
  output logic [DATA_W-1:0] data_out
);

  logic                     s1_valid_reg;
  logic signed [DATA_W-1:0] s1_data_reg;
  logic [GAIN_W-1:0]        s1_gain_reg;
  logic signed [PROD_W-1:0] product;
  logic                     product_unused;

  // Gain is zero-extended so Q1.15 unity stays positive in the signed multiply.
  assign product = s1_data_reg * $signed({1'b0, s1_gain_reg});
  assign product_unused = ^{product[PROD_W-1:DATA_W+GAIN_W-1], product[GAIN_W-2:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_reg <= 1'b0;
      s1_data_reg  <= '0;
      s1_gain_reg  <= '0;
      data_valid   <= 1'b0;
      data_out     <= '0;
    end else begin
      s1_valid_reg <= en;
      if (en) begin
        s1_data_reg <= data_in;
        s1_gain_reg <= gain;
      end
      data_valid <= s1_valid_reg;
      if (s1_valid_reg) begin
        data_out <= product[DATA_W+GAIN_W-2:GAIN_W-1];
      end
    end
  end

endmodule

// File: rtl/output_volume_ramp.sv
// Stereo volume / soft-mute stage with a once-per-frame linear gain ramp.
// Optional peak meter enabled by OUTPUT_VOLUME_PEAK_METER_EN.
module output_volume_ramp
  import output_volume_ramp_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic              mute,
  input  logic [GAIN_W-1:0] target_gain,
  input  logic [7:0]        ramp_step,
  output_volume_ramp_if.slave aud,
  output logic [GAIN_W-1:0] cur_gain,
  output logic              ramping,
  output logic              muted
`ifdef OUTPUT_VOLUME_PEAK_METER_EN
  ,
  input  logic              peak_clr,
  output logic [PEAK_W-1:0] peak_l,
  output logic [PEAK_W-1:0] peak_r
`endif
);

  ramp_state_t       state_reg, state_next;
  logic [GAIN_W-1:0] gain_reg, gain_next;
  logic              frame_tick_reg;
  logic [GAIN_W-1:0] tgt;
  logic [GAIN_W-1:0] step;

  logic              en_ch    [2];
  logic [DATA_W-1:0] din_ch   [2];
  logic              valid_ch [2];
  logic [DATA_W-1:0] dout_ch  [2];

  always_comb begin
    tgt = (target_gain > UNITY) ? UNITY : target_gain;
    if (!run || mute) begin
      tgt = '0;
    end
  end

  assign step = (ramp_step == 8'd0) ? 16'd1 : {8'd0, ramp_step};

  // Direction is re-derived every frame, so retargets never overshoot.
  always_comb begin
    gain_next = gain_reg;
    if (!run) begin
      gain_next = '0;
    end else if (frame_tick_reg) begin
      if (tgt >= gain_reg) begin
        gain_next = ((tgt - gain_reg) <= step) ? tgt : gain_reg + step;
      end else begin
        gain_next = ((gain_reg - tgt) <= step) ? tgt : gain_reg - step;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    if (!run) begin
      state_next = MUTED;
    end else begin
      case (state_reg)
        MUTED: begin
          if (gain_next != tgt) begin
            state_next = RAMP;
          end else if (gain_next != '0) begin
            state_next = STEADY;
          end
        end
        RAMP: begin
          if (gain_next == tgt) begin
            state_next = (tgt == '0) ? MUTED : STEADY;
          end
        end
        STEADY: begin
          if (gain_next != tgt) begin
            state_next = RAMP;
          end
        end
        default: state_next = MUTED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= MUTED;
      gain_reg       <= '0;
      frame_tick_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      gain_reg       <= gain_next;
      frame_tick_reg <= run & aud.r_data_en;
    end
  end

  assign cur_gain = gain_reg;
  assign ramping  = (state_reg == RAMP);
  assign muted    = (gain_reg == '0);

  assign en_ch[0]  = run & aud.l_data_en;
  assign en_ch[1]  = run & aud.r_data_en;
  assign din_ch[0] = aud.l_data_in;
  assign din_ch[1] = aud.r_data_in;

`ifdef OUTPUT_VOLUME_PEAK_METER_EN
  logic [PEAK_W-1:0] peak_ch [2];
`endif

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ch
      volume_mult_pipe u_pipe (
        .clk        (clk),
        .reset      (reset),
        .en         (en_ch[gi]),
        .data_in    (din_ch[gi]),
        .gain       (gain_reg),
        .data_valid (valid_ch[gi]),
        .data_out   (dout_ch[gi])
      );
`ifdef OUTPUT_VOLUME_PEAK_METER_EN
      logic [PEAK_W-1:0] peak_reg;
      logic [PEAK_W-1:0] mag;

      assign mag = abs_sat(dout_ch[gi]);

      // A clear that lands on a valid restarts the peak from that sample.
      always_ff @(posedge clk) begin
        if (reset) begin
          peak_reg <= '0;
        end else if (valid_ch[gi]) begin
          if (peak_clr || (mag > peak_reg)) begin
            peak_reg <= mag;
          end
        end else if (peak_clr) begin
          peak_reg <= '0;
        end
      end

      assign peak_ch[gi] = peak_reg;
`endif
    end
  endgenerate

  assign aud.l_data_valid = valid_ch[0];
  assign aud.r_data_valid = valid_ch[1];
  assign aud.l_data_out   = dout_ch[0];
  assign aud.r_data_out   = dout_ch[1];

`ifdef OUTPUT_VOLUME_PEAK_METER_EN
  assign peak_l = peak_ch[0];
  assign peak_r = peak_ch[1];
`endif

endmodule

// File: tb/tb_output_volume_ramp.sv
// Scoreboard bench for output_volume_ramp: directed frames push expected
// samples and arrival cycles; a negedge monitor pops and compares.
module tb_output_volume_ramp;
  import output_volume_ramp_pkg::*;

  typedef struct {
    logic [23:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic        mute = 1'b0;
  logic [15:0] target_gain = '0;
  logic [7:0]  ramp_step = '0;
  logic [15:0] cur_gain;
  logic        ramping;
  logic        muted;
`ifdef OUTPUT_VOLUME_PEAK_METER_EN
  logic        peak_clr = 1'b0;
  logic [22:0] peak_l;
  logic [22:0] peak_r;
`endif

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  exp_t sb_l[$];
  exp_t sb_r[$];

  output_volume_ramp_if aud ();

  output_volume_ramp dut (
    .clk         (clk),
    .reset       (reset),
    .run         (run),
    .mute        (mute),
    .target_gain (target_gain),
    .ramp_step   (ramp_step),
    .aud         (aud),
    .cur_gain    (cur_gain),
    .ramping     (ramping),
    .muted       (muted)
`ifdef OUTPUT_VOLUME_PEAK_METER_EN
    ,
    .peak_clr    (peak_clr),
    .peak_l      (peak_l),
    .peak_r      (peak_r)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input bit le, input bit re, input logic [23:0] ld, input logic [23:0] rd,
                        input bit pl, input bit pr, input logic [23:0] el, input logic [23:0] er);
    exp_t e;
    aud.l_data_en = le;
    aud.r_data_en = re;
    aud.l_data_in = ld;
    aud.r_data_in = rd;
    if (pl) begin
      e.data = el; e.cyc = cyc + 2; sb_l.push_back(e);
    end
    if (pr) begin
      e.data = er; e.cyc = cyc + 2; sb_r.push_back(e);
    end
    tick();
    aud.l_data_en = 1'b0;
    aud.r_data_en = 1'b0;
  endtask

  task automatic frame(input logic [23:0] ld, input logic [23:0] rd,
                       input logic [23:0] el, input logic [23:0] er);
    strobe(1'b1, 1'b0, ld, 24'h0, 1'b1, 1'b0, el, 24'h0);
    strobe(1'b0, 1'b1, 24'h0, rd, 1'b0, 1'b1, 24'h0, er);
    repeat (4) tick();
  endtask

  // Zero-data frames until the ramp settles; a bound overrun shows as ramping=1.
  task automatic settle(input string name);
    for (int i = 0; i < 200 && ramping; i++) begin
      frame(24'h0, 24'h0, 24'h0, 24'h0);
    end
    check(name, 32'(ramping), 32'd0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (aud.l_data_valid) begin
      if (sb_l.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL l_unexpected_valid: got data %h, expected no valid", aud.l_data_out);
      end else begin
        e = sb_l.pop_front();
        check("l_data", 32'(aud.l_data_out), 32'(e.data));
        check("l_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (aud.r_data_valid) begin
      if (sb_r.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL r_unexpected_valid: got data %h, expected no valid", aud.r_data_out);
      end else begin
        e = sb_r.pop_front();
        check("r_data", 32'(aud.r_data_out), 32'(e.data));
        check("r_latency_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    aud.l_data_en = 1'b0;
    aud.r_data_en = 1'b0;
    aud.l_data_in = '0;
    aud.r_data_in = '0;
    repeat (3) tick();
    check("rst_cur_gain", 32'(cur_gain), 32'h0);
    check("rst_muted", 32'(muted), 32'd1);
    check("rst_ramping", 32'(ramping), 32'd0);
    check("rst_l_valid", 32'(aud.l_data_valid), 32'd0);
    check("rst_r_valid", 32'(aud.r_data_valid), 32'd0);
    check("rst_l_out", 32'(aud.l_data_out), 32'h0);
    check("rst_r_out", 32'(aud.r_data_out), 32'h0);
    reset = 1'b0;
    tick();

    // Unity pass-through
    target_gain = 16'h8000; ramp_step = 8'd255; run = 1'b1;
    tick();
    check("unity_ramp_start", 32'(ramping), 32'd1);
    settle("unity_settle");
    check("unity_gain", 32'(cur_gain), 32'h8000);
    frame(24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000);
    frame(24'h000001, 24'h000001, 24'h000001, 24'h000001);

`ifdef OUTPUT_VOLUME_PEAK_METER_EN
    check("peak_r_saturated", 32'(peak_r), 32'h7FFFFF);
    peak_clr = 1'b1; tick(); peak_clr = 1'b0; tick();
    check("peak_l_cleared", 32'(peak_l), 32'h0);
    strobe(1'b1, 1'b0, 24'hFFFFFB, 24'h0, 1'b1, 1'b0, 24'hFFFFFB, 24'h0);
    strobe(1'b1, 1'b0, 24'h000003, 24'h0, 1'b1, 1'b0, 24'h000003, 24'h0);
    strobe(1'b1, 1'b0, 24'h000007, 24'h0, 1'b1, 1'b0, 24'h000007, 24'h0);
    repeat (4) tick();
    check("peak_l_max", 32'(peak_l), 32'h7);
    strobe(1'b1, 1'b0, 24'hFFFFFE, 24'h0, 1'b1, 1'b0, 24'hFFFFFE, 24'h0);
    tick();
    peak_clr = 1'b1; tick(); peak_clr = 1'b0; tick();
    check("peak_l_clr_with_valid", 32'(peak_l), 32'h2);
`endif

    // Half gain, floor on negative values
    target_gain = 16'h4000;
    tick();
    settle("half_settle");
    check("half_gain", 32'(cur_gain), 32'h4000);
    frame(24'h000003, 24'hFFFFFD, 24'h000001, 24'hFFFFFE);

    // run drop: in-flight sample still emits, later strobes are dropped
    strobe(1'b1, 1'b0, 24'h000006, 24'h0, 1'b1, 1'b0, 24'h000003, 24'h0);
    run = 1'b0;
    tick();
    check("rundrop_gain", 32'(cur_gain), 32'h0);
    check("rundrop_muted", 32'(muted), 32'd1);
    strobe(1'b1, 1'b1, 24'h111111, 24'h222222, 1'b0, 1'b0, 24'h0, 24'h0);
    repeat (4) tick();

    // Ramp timing from run rising: unit-gain probe 0x8000 echoes the gain used
    target_gain = 16'h8000; ramp_step = 8'd128;
    run = 1'b1;
    tick();
    check("ramp_start", 32'(ramping), 32'd1);
    for (int k = 1; k <= 256; k++) begin
      frame(24'h008000, 24'h008000, 24'((k - 1) * 128), 24'((k - 1) * 128));
      check("ramp_gain", 32'(cur_gain), 32'(k * 128));
      if (k >= 255) check("ramp_flag", 32'(ramping), 32'(k < 256));
    end

    // Soft mute from 0x2000 with step 64
    run = 1'b0; tick(); run = 1'b1;
    for (int k = 1; k <= 64; k++) begin
      frame(24'h008000, 24'h008000, 24'((k - 1) * 128), 24'((k - 1) * 128));
    end
    check("premute_gain", 32'(cur_gain), 32'h2000);
    mute = 1'b1; ramp_step = 8'd64;
    tick();
    check("mute_ramping", 32'(ramping), 32'd1);
    for (int k = 1; k <= 128; k++) begin
      frame(24'h008000, 24'h008000, 24'(8192 - (k - 1) * 64), 24'(8192 - (k - 1) * 64));
      check("mute_gain", 32'(cur_gain), 32'(8192 - k * 64));
    end
    check("mute_muted", 32'(muted), 32'd1);
    check("mute_not_ramping", 32'(ramping), 32'd0);

    // Simultaneous and back-to-back strobes at unity
    mute = 1'b0; ramp_step = 8'd255;
    tick();
    settle("b2b_settle");
    check("b2b_gain", 32'(cur_gain), 32'h8000);
    strobe(1'b1, 1'b1, 24'h000100, 24'hFFFF00, 1'b1, 1'b1, 24'h000100, 24'hFFFF00);
    strobe(1'b1, 1'b1, 24'h123456, 24'hFEDCBA, 1'b1, 1'b1, 24'h123456, 24'hFEDCBA);
    strobe(1'b1, 1'b0, 24'h7ABCDE, 24'h0, 1'b1, 1'b0, 24'h7ABCDE, 24'h0);
    repeat (4) tick();

    // Reset mid-ramp discards the pipeline
    target_gain = 16'h4000; ramp_step = 8'd1;
    frame(24'h0, 24'h0, 24'h0, 24'h0);
    check("prereset_ramping", 32'(ramping), 32'd1);
    strobe(1'b1, 1'b0, 24'h123456, 24'h0, 1'b0, 1'b0, 24'h0, 24'h0);
    reset = 1'b1;
    tick();
    check("midreset_gain", 32'(cur_gain), 32'h0);
    check("midreset_muted", 32'(muted), 32'd1);
    check("midreset_ramping", 32'(ramping), 32'd0);
    check("midreset_l_out", 32'(aud.l_data_out), 32'h0);
    check("midreset_r_out", 32'(aud.r_data_out), 32'h0);
    check("midreset_l_valid", 32'(aud.l_data_valid), 32'd0);
    reset = 1'b0;
    repeat (5) tick();

    check("sb_l_drained", 32'(sb_l.size()), 32'd0);
    check("sb_r_drained", 32'(sb_r.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/output_volume_ramp.md
Name: output_volume_ramp

Overview:
- Stereo digital volume / soft-mute stage between the audio output mux and the PCM-to-I2S converter.
- Multiplies each 24-bit PCM sample by a per-frame gain.
- Gain slews linearly toward a CPU-programmed target, so volume changes, mute and run start/stop are click-free.
- Passes the L/R valid strobes through with fixed latency.

Parameters:
- DATA_W, 24, PCM sample width (signed two's complement).
- GAIN_W, 16, gain width; unsigned Q1.15, 16'h8000 = unity.
- UNITY, 16'h8000, maximum applied gain; larger targets are clamped to this value.

Ports:
- clk  in  1  system clock. One clock; reset is synchronous and active-high.
- reset  in  1  synchronous active-high reset.
- run  in  1  audio_control[0]; low forces mute and drops strobes.
- mute  in  1  soft-mute request; effective target becomes 0.
- target_gain  in  16  CPU volume {msb,lsb}, Q1.15.
- ramp_step  in  8  gain increment per frame; 0 is treated as 1.
- l_data_en  in  1  left sample strobe (1 clk).
- r_data_en  in  1  right sample strobe (1 clk); marks end of frame.
- l_data_in  in  24  left PCM sample.
- r_data_in  in  24  right PCM sample.
- l_data_valid  out  1  left output strobe.
- r_data_valid  out  1  right output strobe.
- l_data_out  out  24  scaled left sample.
- r_data_out  out  24  scaled right sample.
- cur_gain  out  16  gain currently applied.
- ramping  out  1  high while gain != effective target.
- muted  out  1  high while cur_gain == 0.

Behaviour:
- Reset values: all outputs 0, except muted=1. cur_gain=0; state MUTED.
- Effective target: tgt = (!run || mute) ? 0 : min(target_gain, UNITY).
- State machine:
  - MUTED (gain 0, tgt 0) -> RAMP when tgt != 0.
  - RAMP -> STEADY when gain reaches tgt (or MUTED if tgt is 0).
  - STEADY -> RAMP when tgt != gain.
- Gain update:
  - Evaluated only in the cycle after r_data_en is registered, i.e. once per frame.
  - If |tgt - gain| <= step, gain = tgt; otherwise gain moves by ±step toward tgt.
  - The direction is recomputed every frame, so a target change mid-ramp reverses or retargets immediately with no overshoot.
- Frame coherency: both samples of a frame use the same gain. The update happens after the R sample, so the next L sample sees the new gain. Simultaneous l/r strobes also share one gain.
- Datapath, per channel:
  - Stage 1: register sample and gain.
  - Stage 2: product = signed sample × {1'b0, gain} (41-bit); out = product[38:15], arithmetic truncation.
  - No saturation is needed because gain <= UNITY. At UNITY the output equals the input exactly.
- Latency: x_data_valid asserts exactly 2 clk after x_data_en; x_data_out is held until the next valid.
- Strobes are independent per channel; back-to-back strobes on consecutive clocks are supported (fully pipelined).
- run low:
  - Incoming strobes are dropped (no valid out).
  - cur_gain is forced to 0 immediately, state MUTED.
  - In-flight pipeline samples still emit.
- run rising: ramp from 0 to target; first frame at gain 0 + step.
- reset mid-ramp: immediate return to reset values; pipeline contents discarded.
- ramping = (state == RAMP); muted = (cur_gain == 0).

Optional Feature:
- Macro: OUTPUT_VOLUME_PEAK_METER_EN.
- When defined:
  - Adds outputs peak_l / peak_r (23 bits each), holding the max |x_data_out| seen.
  - Adds input peak_clr (1 bit); a clr pulse loads 0.
  - If clr coincides with a valid, the peak loads that sample's magnitude.
  - |-2^23| saturates to 23'h7FFFFF.
- When not defined: those ports and registers are absent; the datapath is identical.

Decomposition:
- Shared audio package:
  - DATA_W and GAIN_W constants.
  - UNITY gain constant.
  - Ramp state enum {MUTED, RAMP, STEADY}.
- Natural sub-module: volume_mult_pipe.
  - One-channel, 2-stage multiply/truncate with valid pipe.
  - Instantiated twice.
  - The ramp FSM stays in the top module.

Test Plan:
- Unity pass-through: target=16'h8000, step=255, run=1; wait until STEADY; inputs 24'h7FFFFF, 24'h800000, 24'h000001 -> outputs identical, valid exactly 2 clk after each strobe.
- Half gain: target=16'h4000, steady; input 24'h000003 -> 24'h000001; input 24'hFFFFFD (-3) -> 24'hFFFFFE (-2, floor).
- Ramp timing: run 0->1, target=16'h8000, step=128; drive frames -> cur_gain goes 128, 256, …; ramping drops after frame 256 with cur_gain=16'h8000 and no overshoot.
- Soft mute mid-ramp: at cur_gain=16'h2000 assert mute, step=64 -> gain decreases by 64 per frame; reaches 0 after 128 frames; muted=1, state MUTED; L and R of every frame carry the same gain.
- Edge cases:
  - Simultaneous l/r strobes plus back-to-back strobes -> both channels valid 2 clk later.
  - run dropped -> cur_gain=0 next clk; new strobes produce no valid.
  - reset during ramp -> all outputs 0 on the next clk.
- With OUTPUT_VOLUME_PEAK_METER_EN:
  - Outputs -5, 3, 7 -> peak=7.
  - peak_clr together with a valid of -2 -> peak=2.
  - Output 24'h800000 -> peak=23'h7FFFFF.
